// File: rtl/grf_pkg.sv
// Shared defaults and pending-counter next-state helper for the scoreboarded GRF.
// The helper works at CNT_W_MAX bits; callers narrow the result to their own width.
package grf_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;
    localparam int NRD_DEF    = 2;
    localparam int CNT_W_DEF  = 2;
    localparam int CNT_W_MAX  = 8;

    // Flush wins over everything; a simultaneous issue and retire cancel out.
    // A retire against an empty counter leaves it at zero.
    function automatic logic [CNT_W_MAX-1:0] cnt_next(
        input logic [CNT_W_MAX-1:0] cnt,
        input logic                 inc,
        input logic                 dec,
        input logic                 flush
    );
        logic [CNT_W_MAX-1:0] nxt;
        nxt = cnt;
        if (flush) begin
            nxt = '0;
        end else if (inc && !dec) begin
            nxt = cnt + CNT_W_MAX'(1);
        end else if (dec && !inc && (cnt != '0)) begin
            nxt = cnt - CNT_W_MAX'(1);
        end
        return nxt;
    endfunction

endpackage

// File: rtl/grf_pend_cnt.sv
// One per-register pending-write counter: counts issued but not yet retired writes.
module grf_pend_cnt
    import grf_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             dec,
    input  logic             flush,
    output logic [CNT_W-1:0] cnt,
    output logic             busy,
    output logic             full,
    output logic             underflow
);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= CNT_W'(cnt_next(CNT_W_MAX'(cnt_q), inc, dec, flush));
        end
    end

    assign cnt       = cnt_q;
    assign busy      = (cnt_q != '0);
    assign full      = &cnt_q;
    // A retire with nothing pending is only legal when flush or a same-cycle issue covers it.
    assign underflow = dec && !inc && !flush && (cnt_q == '0);

endmodule

// File: rtl/grf_scoreboard.sv
// General register file with write-to-read bypass, hardwired zero register and
// a per-register pending-write scoreboard exposed through read-port busy flags.
module grf_scoreboard
    import grf_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int NRD    = NRD_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NRD*ADDR_W-1:0] rd_addr,
    output logic [NRD*DATA_W-1:0] rd_data,
    output logic [NRD-1:0]        rd_busy,
    input  logic                  iss_valid,
    input  logic [ADDR_W-1:0]     iss_addr,
    output logic                  iss_ready,
    input  logic                  we,
    input  logic [ADDR_W-1:0]     wr_addr,
    input  logic [DATA_W-1:0]     wr_data,
    input  logic [31:0]           wr_pc,
    input  logic                  flush,
    output logic                  err
);

    localparam int NREG = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [NREG];
    logic [CNT_W-1:0]  cnt_v [NREG];
    logic              busy_v [NREG];
    logic              full_v [NREG];
    logic              underflow_v [NREG];
    logic              iss_acc;
    logic              any_underflow;
    logic              unused_wr_pc;

    // wr_pc only feeds the external write trace monitor.
    assign unused_wr_pc = ^wr_pc;

    // iss_valid/iss_ready: a reservation of iss_addr transfers on a rising edge where
    // both are high, iss_addr is nonzero and flush is low. iss_ready is a function of
    // iss_addr and the counters only, never of iss_valid, so stall logic cannot loop.
    assign iss_ready = !full_v[iss_addr];
    assign iss_acc   = iss_valid && iss_ready && (iss_addr != '0) && !flush;

    assign cnt_v[0]       = '0;
    assign busy_v[0]      = 1'b0;
    assign full_v[0]      = 1'b0;
    assign underflow_v[0] = 1'b0;

    for (genvar r = 1; r < NREG; r++) begin : g_cnt
        grf_pend_cnt #(
            .CNT_W(CNT_W)
        ) u_cnt (
            .clk       (clk),
            .reset     (reset),
            .inc       (iss_acc && (iss_addr == ADDR_W'(r))),
            .dec       (we && (wr_addr == ADDR_W'(r))),
            .flush     (flush),
            .cnt       (cnt_v[r]),
            .busy      (busy_v[r]),
            .full      (full_v[r]),
            .underflow (underflow_v[r])
        );
    end

    always_comb begin
        any_underflow = 1'b0;
        for (int r = 1; r < NREG; r++) begin
            any_underflow = any_underflow | underflow_v[r];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err <= 1'b0;
        end else if (any_underflow) begin
            err <= 1'b1;
        end
    end

    // Entry 0 is never written, so it reads as zero without a special case in the mux.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int r = 0; r < NREG; r++) begin
                mem[r] <= '0;
            end
        end else if (we && (wr_addr != '0)) begin
            mem[wr_addr] <= wr_data;
        end
    end

    for (genvar p = 0; p < NRD; p++) begin : g_rd
        logic [ADDR_W-1:0] a;
        logic              hit;

        assign a   = rd_addr[p*ADDR_W +: ADDR_W];
        assign hit = we && (wr_addr == a) && (a != '0);

        assign rd_data[p*DATA_W +: DATA_W] = hit ? wr_data : mem[a];
        // The last outstanding write retiring this cycle releases the reader immediately.
        assign rd_busy[p] = busy_v[a] && !(hit && (cnt_v[a] == CNT_W'(1)) && !flush);
    end

endmodule

// File: tb/tb_grf_scoreboard.sv
// Self-checking bench for grf_scoreboard: directed scenarios plus randomized traffic
// compared against a behavioural register/pending-count model via an expected queue.
module tb_grf_scoreboard;

    localparam int DATA_W  = 32;
    localparam int ADDR_W  = 5;
    localparam int NRD     = 2;
    localparam int CNT_W   = 2;
    localparam int NREG    = 32;
    localparam int CNT_MAX = 3;
    localparam int W       = 32;

    logic                  clk;
    logic                  reset;
    logic [NRD*ADDR_W-1:0] rd_addr;
    logic [NRD*DATA_W-1:0] rd_data;
    logic [NRD-1:0]        rd_busy;
    logic                  iss_valid;
    logic [ADDR_W-1:0]     iss_addr;
    logic                  iss_ready;
    logic                  we;
    logic [ADDR_W-1:0]     wr_addr;
    logic [DATA_W-1:0]     wr_data;
    logic [31:0]           wr_pc;
    logic                  flush;
    logic                  err;

    grf_scoreboard #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NRD(NRD), .CNT_W(CNT_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .rd_busy   (rd_busy),
        .iss_valid (iss_valid),
        .iss_addr  (iss_addr),
        .iss_ready (iss_ready),
        .we        (we),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .wr_pc     (wr_pc),
        .flush     (flush),
        .err       (err)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (reset && we && (wr_addr != '0))
            $display("%0t@%h: $%0d <= %h", $time, wr_pc, wr_addr, wr_data);
    end

    // ---------------- scoreboard state ----------------
    int              n_checks;
    int              n_errors;
    logic [W-1:0]    exp_q[$];
    logic [DATA_W-1:0] mem_m [NREG];
    int              cnt_m [NREG];
    logic            err_m;

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int r = 0; r < NREG; r++) begin
            mem_m[r] = '0;
            cnt_m[r] = 0;
        end
        err_m = 1'b0;
    endtask

    task automatic push_expected();
        logic [NRD-1:0] bz;
        bz = '0;
        for (int p = 0; p < NRD; p++) begin
            int a;
            a = int'(rd_addr[p*ADDR_W +: ADDR_W]);
            if (a == 0) exp_q.push_back('0);
            else if (we && int'(wr_addr) == a) exp_q.push_back(wr_data);
            else exp_q.push_back(mem_m[a]);
            bz[p] = (a != 0) && (cnt_m[a] != 0) &&
                    !(we && int'(wr_addr) == a && cnt_m[a] == 1 && !flush);
        end
        exp_q.push_back(W'(bz));
        exp_q.push_back(W'((iss_addr == '0) || (cnt_m[int'(iss_addr)] != CNT_MAX)));
        exp_q.push_back(W'(err_m));
    endtask

    task automatic pop_check();
        for (int p = 0; p < NRD; p++) begin
            check($sformatf("rd_data%0d", p), rd_data[p*DATA_W +: DATA_W], exp_q.pop_front());
        end
        check("rd_busy", W'(rd_busy), exp_q.pop_front());
        check("iss_ready", W'(iss_ready), exp_q.pop_front());
        check("err", W'(err), exp_q.pop_front());
    endtask

    task automatic model_update();
        int   ia;
        int   wa;
        logic acc;
        logic ret;
        ia  = int'(iss_addr);
        wa  = int'(wr_addr);
        acc = iss_valid && !flush && (ia != 0) && (cnt_m[ia] != CNT_MAX);
        ret = we && (wa != 0);
        if (ret && !flush && cnt_m[wa] == 0 && !(acc && ia == wa)) err_m = 1'b1;
        if (flush) begin
            for (int r = 0; r < NREG; r++) cnt_m[r] = 0;
        end else begin
            if (acc && !(ret && wa == ia)) cnt_m[ia] = cnt_m[ia] + 1;
            if (ret && !(acc && wa == ia) && cnt_m[wa] != 0) cnt_m[wa] = cnt_m[wa] - 1;
        end
        if (ret) mem_m[wa] = wr_data;
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive_idle();
        iss_valid = 1'b0;
        iss_addr  = '0;
        we        = 1'b0;
        wr_addr   = '0;
        wr_data   = '0;
        flush     = 1'b0;
    endtask

    task automatic set_rd(input int a0, input int a1);
        rd_addr = {ADDR_W'(a1), ADDR_W'(a0)};
    endtask

    task automatic drive_issue(input int a);
        iss_valid = 1'b1;
        iss_addr  = ADDR_W'(a);
    endtask

    task automatic drive_write(input int a, input logic [DATA_W-1:0] d);
        we      = 1'b1;
        wr_addr = ADDR_W'(a);
        wr_data = d;
    endtask

    task automatic eval();
        push_expected();
        #1;
        pop_check();
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        wr_pc = wr_pc + 32'd4;
        @(negedge clk);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        n_checks = 0;
        n_errors = 0;
        wr_pc    = 32'h0000_1000;
        rd_addr  = '0;
        drive_idle();
        model_reset();
        reset = 1'b1;
        #1 reset = 1'b0;
        #2;
        check("rst_rd_data", W'(rd_data), '0);
        check("rst_rd_busy", W'(rd_busy), '0);
        check("rst_iss_ready", W'(iss_ready), W'(1));
        check("rst_err", W'(err), '0);
        @(negedge clk);
        reset = 1'b1;

        // write with same-cycle bypass, then storage read; register 0 reads zero
        drive_write(5, 32'h1234_5678); set_rd(5, 0);
        eval();
        check("bypass", rd_data[DATA_W-1:0], 32'h1234_5678);
        tick();
        drive_idle(); set_rd(5, 0);
        eval();
        check("stored", rd_data[DATA_W-1:0], 32'h1234_5678);
        check("reg0", rd_data[2*DATA_W-1:DATA_W], '0);
        tick();

        // issue latency and same-cycle retire release
        drive_issue(8); set_rd(8, 0);
        eval();
        check("busy_issue_cycle", W'(rd_busy[0]), '0);
        tick();
        drive_idle(); set_rd(8, 0);
        eval();
        check("busy_after_issue", W'(rd_busy[0]), W'(1));
        tick();
        drive_write(8, 32'h0000_00AA); set_rd(8, 0);
        eval();
        check("busy_retire_cycle", W'(rd_busy[0]), '0);
        check("data_retire_cycle", rd_data[DATA_W-1:0], 32'h0000_00AA);
        tick();

        // fill the counter for $3
        for (int i = 0; i < 3; i++) begin
            drive_idle(); drive_issue(3);
            eval();
            tick();
        end
        drive_idle(); iss_addr = ADDR_W'(3);
        eval();
        check("ready_full", W'(iss_ready), '0);
        iss_addr = ADDR_W'(4);
        eval();
        check("ready_other", W'(iss_ready), W'(1));
        iss_addr = ADDR_W'(3);
        drive_write(3, 32'h0000_0033);
        eval();
        tick();
        drive_idle(); iss_addr = ADDR_W'(3);
        eval();
        check("ready_after_retire", W'(iss_ready), W'(1));

        // simultaneous issue and retire keep $9 pending
        drive_idle(); drive_issue(9);
        eval();
        tick();
        drive_issue(9); drive_write(9, 32'h0000_0099); set_rd(9, 0);
        eval();
        tick();
        drive_idle(); set_rd(9, 0);
        eval();
        check("busy_iss_ret", W'(rd_busy[0]), W'(1));
        check("data_iss_ret", rd_data[DATA_W-1:0], 32'h0000_0099);

        // retire with nothing pending sets sticky err
        drive_write(10, 32'h0000_0010); set_rd(10, 0);
        eval();
        tick();
        drive_idle();
        eval();
        check("err_set", W'(err), W'(1));
        tick();
        eval();
        check("err_sticky", W'(err), W'(1));

        // flush clears all pending counts, not err
        flush = 1'b1; set_rd(3, 9);
        eval();
        tick();
        drive_idle(); set_rd(3, 9);
        eval();
        check("flush_busy", W'(rd_busy), '0);
        check("flush_err", W'(err), W'(1));
        tick();

        // asynchronous reset mid-cycle
        drive_issue(3);
        eval();
        tick();
        drive_idle(); set_rd(5, 3); iss_addr = ADDR_W'(3);
        eval();
        check("pre_rst_data", rd_data[DATA_W-1:0], 32'h1234_5678);
        check("pre_rst_busy", W'(rd_busy[1]), W'(1));
        #2 reset = 1'b0;
        #1;
        check("async_rst_data", W'(rd_data), '0);
        check("async_rst_busy", W'(rd_busy), '0);
        check("async_rst_err", W'(err), '0);
        model_reset();
        @(negedge clk);
        reset = 1'b1;

        // randomized traffic against the model
        for (int n = 0; n < 600; n++) begin
            iss_valid = ($urandom_range(0, 2) != 0);
            iss_addr  = ADDR_W'($urandom_range(0, 7));
            we        = ($urandom_range(0, 2) == 0);
            wr_addr   = ADDR_W'($urandom_range(0, 7));
            wr_data   = $urandom;
            flush     = ($urandom_range(0, 24) == 0);
            set_rd($urandom_range(0, 7), $urandom_range(0, 7));
            eval();
            tick();
        end
        drive_idle();

        if (exp_q.size() != 0) check("exp_q_empty", W'(exp_q.size()), '0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
